ad_ip_jesd204_tpl_dac_channel_src: RTL and testbench

AD_IP_JESD204_TPL_DAC_CHANNEL_SRC -- requirements
Module: ad_ip_jesd204_tpl_dac_channel_src

---
 rtl/ad_ip_jesd204_tpl_dac_channel_src_if.sv | 22 ++
 rtl/ad_ip_jesd204_tpl_dac_channel_src.sv | 155 +++++++++++++++
 tb/tb_ad_ip_jesd204_tpl_dac_channel_src.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ad_ip_jesd204_tpl_dac_channel_src_if.sv
// DMA sample stream feeding one DAC channel source selector.
// The master drives samples and valid; the slave (channel source) returns ready.
interface ad_ip_jesd204_tpl_dac_channel_src_if #(
    parameter int BITS_PER_SAMPLE = 16,
    parameter int DATA_PATH_WIDTH = 2
);
    logic [BITS_PER_SAMPLE*DATA_PATH_WIDTH-1:0] dma_data;
    logic                                       dma_valid;
    logic                                       dma_ready;

    modport master (
        output dma_data,
        output dma_valid,
        input  dma_ready
    );

    modport slave (
        input  dma_data,
        input  dma_valid,
        output dma_ready
    );
endinterface

// File: rtl/ad_ip_jesd204_tpl_dac_channel_src.sv
// DAC channel source selector: zero, pattern, DMA, ramp, PN7 and PN15 generators
// feeding a single registered converter-sample word.
module ad_ip_jesd204_tpl_dac_channel_src #(
    parameter int CONVERTER_RESOLUTION = 14,
    parameter int DATA_PATH_WIDTH      = 2,
    parameter int BITS_PER_SAMPLE      = 16
) (
    input  logic                                            clk,
    input  logic                                            resetn,
    ad_ip_jesd204_tpl_dac_channel_src_if.slave              dma,
    input  logic [3:0]                                      data_sel,
    input  logic [15:0]                                     pat_data_1,
    input  logic [15:0]                                     pat_data_2,
    input  logic                                            dfmt_enable,
    input  logic                                            dfmt_type,
    input  logic                                            pn_err_inject,
    output logic [CONVERTER_RESOLUTION*DATA_PATH_WIDTH-1:0] data_out,
    output logic                                            dma_underflow
);

    localparam int CR  = CONVERTER_RESOLUTION;
    localparam int DPW = DATA_PATH_WIDTH;
    localparam int BPS = BITS_PER_SAMPLE;
    localparam int OW  = CR * DPW;

    localparam logic [3:0] SEL_ZERO = 4'd0;
    localparam logic [3:0] SEL_PAT  = 4'd1;
    localparam logic [3:0] SEL_DMA  = 4'd2;
    localparam logic [3:0] SEL_RAMP = 4'd3;
    localparam logic [3:0] SEL_PN7  = 4'd4;
    localparam logic [3:0] SEL_PN15 = 4'd5;

    localparam logic [6:0]  PN7_SEED  = '1;
    localparam logic [14:0] PN15_SEED = '1;

    function automatic logic [CR-1:0] trunc_pat(input logic [15:0] w);
        return w[15 -: CR];
    endfunction

    // Offset-binary conversion flips the MSB of a two's-complement sample.
    function automatic logic [CR-1:0] fmt_sample(input logic [CR-1:0] s,
                                                 input logic en,
                                                 input logic typ);
        return (en && !typ) ? {~s[CR-1], s[CR-2:0]} : s;
    endfunction

    logic [OW-1:0] data_q,  data_d;
    logic          uf_q,    uf_d;
    logic [CR-1:0] ramp_q,  ramp_d;
    logic          phase_q, phase_d;
    logic [6:0]    pn7_q,   pn7_d;
    logic [14:0]   pn15_q,  pn15_d;
    logic [3:0]    sel_q;

    logic          sel_change;
    logic [CR-1:0] ramp_cur;
    logic          phase_cur;
    logic [6:0]    pn7_cur,  pn7_nxt;
    logic [14:0]   pn15_cur, pn15_nxt;
    logic [OW-1:0] pn7_word, pn15_word;

    // A new selection restarts every generator from its seed in the same cycle.
    assign sel_change = (data_sel != sel_q);
    assign ramp_cur   = sel_change ? '0 : ramp_q;
    assign phase_cur  = sel_change ? 1'b0 : phase_q;
    assign pn7_cur    = sel_change ? PN7_SEED : pn7_q;
    assign pn15_cur   = sel_change ? PN15_SEED : pn15_q;

    assign dma.dma_ready = (data_sel == SEL_DMA);

    // Serial LFSR unrolled across the whole output word; bit b lands MSB-first in sample b/CR.
    always_comb begin
        pn7_nxt   = pn7_cur;
        pn15_nxt  = pn15_cur;
        pn7_word  = '0;
        pn15_word = '0;
        for (int b = 0; b < OW; b++) begin
            pn7_word[(b / CR) * CR + (CR - 1 - (b % CR))]  = pn7_nxt[6] ^ pn7_nxt[5];
            pn7_nxt                                         = {pn7_nxt[5:0], pn7_nxt[6] ^ pn7_nxt[5]};
            pn15_word[(b / CR) * CR + (CR - 1 - (b % CR))] = pn15_nxt[14] ^ pn15_nxt[13];
            pn15_nxt                                        = {pn15_nxt[13:0], pn15_nxt[14] ^ pn15_nxt[13]};
        end
    end

    always_comb begin
        data_d  = '0;
        uf_d    = 1'b0;
        ramp_d  = ramp_q;
        phase_d = phase_q;
        pn7_d   = pn7_q;
        pn15_d  = pn15_q;
        case (data_sel)
            SEL_PAT: begin
                for (int n = 0; n < DPW; n++) begin
                    data_d[n*CR +: CR] = fmt_sample(
                        trunc_pat((phase_cur ^ (n % 2 == 1)) ? pat_data_2 : pat_data_1),
                        dfmt_enable, dfmt_type);
                end
                phase_d = phase_cur ^ (DPW % 2 == 1);
            end
            SEL_DMA: begin
                if (dma.dma_valid) begin
                    for (int n = 0; n < DPW; n++) begin
                        data_d[n*CR +: CR] = fmt_sample(dma.dma_data[n*BPS + BPS - CR +: CR],
                                                        dfmt_enable, dfmt_type);
                    end
                end else begin
                    uf_d = 1'b1;
                end
            end
            SEL_RAMP: begin
                for (int n = 0; n < DPW; n++) begin
                    data_d[n*CR +: CR] = ramp_cur + CR'(n);
                end
                ramp_d = ramp_cur + CR'(DPW);
            end
            SEL_PN7: begin
                data_d    = pn7_word;
                data_d[0] = pn7_word[0] ^ pn_err_inject;
                pn7_d     = pn7_nxt;
            end
            SEL_PN15: begin
                data_d    = pn15_word;
                data_d[0] = pn15_word[0] ^ pn_err_inject;
                pn15_d    = pn15_nxt;
            end
            default: data_d = '0;
        endcase
    end

    // Output register and generator state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_q  <= '0;
            uf_q    <= 1'b0;
            ramp_q  <= '0;
            phase_q <= 1'b0;
            pn7_q   <= PN7_SEED;
            pn15_q  <= PN15_SEED;
            sel_q   <= SEL_ZERO;
        end else begin
            data_q  <= data_d;
            uf_q    <= uf_d;
            ramp_q  <= ramp_d;
            phase_q <= phase_d;
            pn7_q   <= pn7_d;
            pn15_q  <= pn15_d;
            sel_q   <= data_sel;
        end
    end

    assign data_out      = data_q;
    assign dma_underflow = uf_q;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_channel_src.sv
// Scoreboard bench for the DAC channel source: stimulus pushes expected words,
// a monitor pops one per clock edge and compares.
module tb_ad_ip_jesd204_tpl_dac_channel_src;

    localparam int CR = 14;
    localparam int DPW = 2;
    localparam int BPS = 16;
    localparam int OW = CR * DPW;

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic [3:0]    data_sel = '0;
    logic [15:0]   pat_data_1 = '0;
    logic [15:0]   pat_data_2 = '0;
    logic          dfmt_enable = 1'b0;
    logic          dfmt_type = 1'b0;
    logic          pn_err_inject = 1'b0;
    logic [OW-1:0] data_out;
    logic          dma_underflow;

    ad_ip_jesd204_tpl_dac_channel_src_if #(.BITS_PER_SAMPLE(BPS), .DATA_PATH_WIDTH(DPW)) dma_bus ();

    ad_ip_jesd204_tpl_dac_channel_src #(
        .CONVERTER_RESOLUTION(CR),
        .DATA_PATH_WIDTH(DPW),
        .BITS_PER_SAMPLE(BPS)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .dma(dma_bus.slave),
        .data_sel(data_sel),
        .pat_data_1(pat_data_1),
        .pat_data_2(pat_data_2),
        .dfmt_enable(dfmt_enable),
        .dfmt_type(dfmt_type),
        .pn_err_inject(pn_err_inject),
        .data_out(data_out),
        .dma_underflow(dma_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OW-1:0] data;
        logic          uf;
        logic          rdy;
        string         nm;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;

    logic [6:0]    m_pn7;
    logic [14:0]   m_pn15;
    logic [CR-1:0] m_ramp;

    // Reference LFSRs, stepped one bit at a time; sample 0 first, MSB first.
    function automatic logic [OW-1:0] pn7_ref();
        logic [OW-1:0] w;
        logic nb;
        w = '0;
        for (int n = 0; n < DPW; n++)
            for (int b = 0; b < CR; b++) begin
                nb = m_pn7[6] ^ m_pn7[5];
                m_pn7 = {m_pn7[5:0], nb};
                w[n*CR + CR - 1 - b] = nb;
            end
        return w;
    endfunction

    function automatic logic [OW-1:0] pn15_ref();
        logic [OW-1:0] w;
        logic nb;
        w = '0;
        for (int n = 0; n < DPW; n++)
            for (int b = 0; b < CR; b++) begin
                nb = m_pn15[14] ^ m_pn15[13];
                m_pn15 = {m_pn15[13:0], nb};
                w[n*CR + CR - 1 - b] = nb;
            end
        return w;
    endfunction

    task automatic issue(input logic rst_v, input logic [3:0] sel, input logic vld,
                         input logic inj, input logic fen, input logic fty,
                         input logic [OW-1:0] ed, input logic euf, input string nm);
        exp_t e;
        @(negedge clk);
        resetn            = rst_v;
        data_sel          = sel;
        dma_bus.dma_valid = vld;
        pn_err_inject     = inj;
        dfmt_enable       = fen;
        dfmt_type         = fty;
        e.data = ed;
        e.uf   = euf;
        e.rdy  = (sel == 4'd2);
        e.nm   = nm;
        sbq.push_back(e);
    endtask

    // Monitor: one expected entry per clock edge, sampled just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                exp_t e;
                e = sbq.pop_front();
                checks++;
                if (data_out !== e.data || dma_underflow !== e.uf || dma_bus.dma_ready !== e.rdy) begin
                    errors++;
                    $display("FAIL %s: got data_out=%h underflow=%b ready=%b, want data_out=%h underflow=%b ready=%b",
                             e.nm, data_out, dma_underflow, dma_bus.dma_ready, e.data, e.uf, e.rdy);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    localparam logic [OW-1:0] PAT_RAW = {14'h1555, 14'h2AAA};
    localparam logic [OW-1:0] PAT_FMT = {14'h3555, 14'h0AAA};
    localparam logic [OW-1:0] DMA_RAW = {14'h2001, 14'h1FFF};
    localparam logic [OW-1:0] DMA_FMT = {14'h0001, 14'h3FFF};

    initial begin
        logic [OW-1:0] ed;
        dma_bus.dma_valid = 1'b0;
        dma_bus.dma_data  = {16'h8004, 16'h7FFC};
        pat_data_1        = 16'hAAAA;
        pat_data_2        = 16'h5555;

        // Asynchronous reset before any clock edge
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (data_out !== '0 || dma_underflow !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_init: got data_out=%h underflow=%b, want 0 0", data_out, dma_underflow);
        end
        for (int i = 0; i < 2; i++) issue(1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, "reset_hold");
        issue(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, "zero_src");
        issue(1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, "invalid_sel");

        // Pattern: raw, injection ignored, dfmt_type=1 passthrough, offset binary
        for (int i = 0; i < 3; i++) issue(1'b1, 4'd1, 1'b0, i == 1, 1'b0, 1'b0, PAT_RAW, 1'b0, "pattern_raw");
        issue(1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 1'b1, PAT_RAW, 1'b0, "pattern_dfmt_type1");
        for (int i = 0; i < 2; i++) issue(1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, PAT_FMT, 1'b0, "pattern_offset_bin");

        // DMA: valid toggling, underflow on invalid, formatting
        for (int i = 0; i < 5; i++)
            issue(1'b1, 4'd2, (i % 2) == 0, 1'b0, 1'b0, 1'b0, (i % 2) == 0 ? DMA_RAW : '0, (i % 2) != 0, "dma_toggle");
        issue(1'b1, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0, DMA_FMT, 1'b0, "dma_offset_bin");
        issue(1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1, "dma_underflow_fmt");

        // PN7 with one injected error on cycle 10
        m_pn7 = 7'h7F;
        for (int i = 0; i < 20; i++) begin
            ed = pn7_ref();
            if (i == 10) ed[0] = ~ed[0];
            issue(1'b1, 4'd4, 1'b0, i == 10, 1'b0, 1'b0, ed, 1'b0, i == 10 ? "pn7_inject" : "pn7_seq");
        end

        // Ramp over a full wrap plus one
        m_ramp = '0;
        for (int i = 0; i < 8193; i++) begin
            ed = {m_ramp + 14'd1, m_ramp};
            issue(1'b1, 4'd3, 1'b0, i == 5, 1'b0, 1'b0, ed, 1'b0, i >= 8191 ? "ramp_wrap" : "ramp_seq");
            m_ramp = m_ramp + 14'd2;
        end
        issue(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, "ramp_leave");
        issue(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, {14'd1, 14'd0}, 1'b0, "ramp_restart");
        issue(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, {14'd3, 14'd2}, 1'b0, "ramp_restart_next");

        // PN15 entered with an injection on its first cycle
        m_pn15 = 15'h7FFF;
        for (int i = 0; i < 6; i++) begin
            ed = pn15_ref();
            if (i == 0) ed[0] = ~ed[0];
            issue(1'b1, 4'd5, 1'b0, i == 0, 1'b0, 1'b0, ed, 1'b0, i == 0 ? "pn15_change_inject" : "pn15_seq");
        end

        // Reset between edges in the middle of PN15
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        checks++;
        if (data_out !== '0 || dma_underflow !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_mid: got data_out=%h underflow=%b, want 0 0", data_out, dma_underflow);
        end
        issue(1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, "pn15_reset_hold");
        m_pn15 = 15'h7FFF;
        for (int i = 0; i < 4; i++) begin
            ed = pn15_ref();
            issue(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, ed, 1'b0, "pn15_after_reset");
        end
        issue(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, "zero_final");

        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
